// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing multiply sequencer.
package sc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int           LFSR_W    = 31;
  localparam logic [30:0]  SEED_A    = 31'h1;
  localparam logic [30:0]  SEED_B    = 31'h2;
  localparam int           TAP_A     = 27;
  localparam int           TAP_B     = 2;
  localparam logic         MODE_AND  = 1'b0;
  localparam logic         MODE_XNOR = 1'b1;
  localparam int           BASE_LEN  = 16;
endpackage

// File: rtl/sc_lfsr31.sv
// 31-bit Fibonacci LFSR: feedback = s[30] ^ s[TAP], shifted in at bit 0.
module sc_lfsr31 import sc_pkg::*; #(
  parameter int          TAP  = TAP_A,
  parameter logic [30:0] SEED = SEED_A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  output logic [LFSR_W-1:0] lfsr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lfsr <= SEED;
    else if (load)  lfsr <= SEED;
    else if (step)  lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[TAP]};
  end
endmodule

// File: rtl/sc_mult_sequencer.sv
// Stochastic-computing multiplier sequencer: runs L-bit product streams and counts 1s.
// Build option SC_RESEED_EN: reseed both LFSRs on every accepted start.
module sc_mult_sequencer import sc_pkg::*; #(
  parameter int BITS  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [BITS-1:0]  op_a,
  input  logic [BITS-1:0]  op_b,
  input  logic             mode,
  input  logic [1:0]       len_sel,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result
);
  state_t             state_q, state_d;
  logic [BITS-1:0]    op_a_q, op_b_q;
  logic               mode_q;
  logic [1:0]         len_sel_q;
  logic [CNT_W-1:0]   stream_cnt, ones_cnt, result_q, len_m1;
  logic               sn_a, sn_b, sn_vld, prod;
  logic               accept, run_step, reseed;
  logic [LFSR_W-1:0]  lfsr_a, lfsr_b;
  logic               unused_lfsr_bits;

  assign accept   = (state_q == S_IDLE) && start && !abort;
  assign run_step = (state_q == S_RUN) && !abort;
  assign len_m1   = CNT_W'((BASE_LEN << len_sel_q) - 1);
  assign prod     = (mode_q == MODE_XNOR) ? ~(sn_a ^ sn_b) : (sn_a & sn_b);
  assign result   = result_q;
  assign unused_lfsr_bits = ^{lfsr_a[LFSR_W-BITS-1:0], lfsr_b[LFSR_W-BITS-1:0]};

`ifdef SC_RESEED_EN
  assign reseed = accept;
`else
  assign reseed = 1'b0;
`endif

  sc_lfsr31 #(.TAP(TAP_A), .SEED(SEED_A)) u_lfsr_a (
    .clk(clk), .rst_n(rst_n), .step(run_step), .load(reseed), .lfsr(lfsr_a));
  sc_lfsr31 #(.TAP(TAP_B), .SEED(SEED_B)) u_lfsr_b (
    .clk(clk), .rst_n(rst_n), .step(run_step), .load(reseed), .lfsr(lfsr_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start && !abort) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort)                     state_d = S_IDLE;
        else if (stream_cnt == len_m1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SN bits sample the LFSR state present before this cycle's step; the
  // product of those bits is counted one cycle later (sn_vld gates the first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      mode_q     <= 1'b0;
      len_sel_q  <= '0;
      stream_cnt <= '0;
      ones_cnt   <= '0;
      result_q   <= '0;
      sn_a       <= 1'b0;
      sn_b       <= 1'b0;
      sn_vld     <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q     <= op_a;
        op_b_q     <= op_b;
        mode_q     <= mode;
        len_sel_q  <= len_sel;
        stream_cnt <= '0;
        ones_cnt   <= '0;
        sn_vld     <= 1'b0;
      end
      if (run_step) begin
        sn_a       <= lfsr_a[LFSR_W-1 -: BITS] < op_a_q;
        sn_b       <= lfsr_b[LFSR_W-1 -: BITS] < op_b_q;
        sn_vld     <= 1'b1;
        stream_cnt <= stream_cnt + 1'b1;
        if (sn_vld) ones_cnt <= ones_cnt + CNT_W'(prod);
      end
      if (state_q == S_DRAIN && !abort) begin
        ones_cnt <= ones_cnt + CNT_W'(prod);
        result_q <= ones_cnt + CNT_W'(prod);
      end
    end
  end
endmodule

// File: tb/tb_sc_mult_sequencer.sv
// Self-checking bench: directed table, corner sequences and random ops vs. a stream model.
module tb_sc_mult_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, mode;
  logic [3:0] op_a, op_b;
  logic [1:0] len_sel;
  logic       ready, busy, done;
  logic [7:0] result;

  int checks = 0;
  int failures = 0;
  logic [30:0] ma, mb;
  logic [7:0]  last_res;

  always #5 clk = ~clk;

  sc_mult_sequencer #(.BITS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .mode(mode), .len_sel(len_sel),
    .ready(ready), .busy(busy), .done(done), .result(result));

  typedef struct {
    logic       md;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] ls;
    int         restart_at;
    bit         abort_done;
    int         lo;
    int         hi;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [30:0] lfsr_next(input logic [30:0] s, input int tap);
    return {s[29:0], s[30] ^ s[tap]};
  endfunction

  // Reference: n stream bits, each from the generator state before its step.
  function automatic int model_run(input logic m, input logic [3:0] a, input logic [3:0] b, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) begin
      logic sa, sb;
      sa = ma[30:27] < a;
      sb = mb[30:27] < b;
      ones += m ? int'(sa == sb) : int'(sa && sb);
      ma = lfsr_next(ma, 27);
      mb = lfsr_next(mb, 2);
    end
    return ones;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic do_op(input logic md, input logic [3:0] a, input logic [3:0] b, input logic [1:0] ls,
                       input int abort_at, input int restart_at, input bit abort_done, input int ncyc,
                       output int done_cyc, output int ndone, output logic [7:0] res, output int hs_err);
    int L;
    logic er, eb, ed;
    L = 16 << ls;
    mode = md; op_a = a; op_b = b; len_sel = ls; start = 1'b1; abort = 1'b0;
    @(posedge clk);
    done_cyc = 0; ndone = 0; res = '0; hs_err = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (abort_at > 0) begin
        eb = (c <= abort_at); er = !eb; ed = 1'b0;
      end else begin
        eb = (c <= L + 1); ed = (c == L + 2); er = (c >= L + 3);
      end
      if ({ready, busy, done} !== {er, eb, ed}) hs_err++;
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) begin done_cyc = c; res = result; end
      end
      start = (c == restart_at);
      abort = (c == abort_at) || (abort_done && c == L + 2);
      mode = 1'($urandom); op_a = 4'($urandom); op_b = 4'($urandom); len_sel = 2'($urandom);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic full_op(input string name, input logic md, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] ls, input int restart_at, input bit abort_done, input int ncyc,
                         input int lo, input int hi);
    int L, exp, dc, nd, hs;
    logic [7:0] r;
    L = 16 << ls;
`ifdef SC_RESEED_EN
    ma = 31'h1; mb = 31'h2;
`endif
    exp = model_run(md, a, b, L);
    do_op(md, a, b, ls, 0, restart_at, abort_done, (ncyc > 0) ? ncyc : L + 6, dc, nd, r, hs);
    check({name, " done_cycle"}, dc, L + 2);
    check({name, " done_count"}, nd, 1);
    check({name, " result"}, r, exp);
    check({name, " in_range"}, (int'(r) >= lo && int'(r) <= hi), 1);
    check({name, " handshake_errs"}, hs, 0);
    check({name, " result_hold"}, result, r);
    last_res = r;
  endtask

  initial begin
    vec_t tbl[6];
    int   err, dc, nd, hs;
    logic [7:0] r, r1;

    tbl[0] = '{1'b0, 4'd0,  4'd9,  2'd0, 0, 1'b0, 0,   0};
    tbl[1] = '{1'b1, 4'd0,  4'd0,  2'd3, 0, 1'b0, 128, 128};
`ifdef SC_RESEED_EN
    tbl[2] = '{1'b0, 4'd8,  4'd8,  2'd3, 5, 1'b0, 0,   128};
`else
    tbl[2] = '{1'b0, 4'd8,  4'd8,  2'd3, 5, 1'b0, 16,  48};
`endif
    tbl[3] = '{1'b1, 4'd15, 4'd0,  2'd1, 0, 1'b0, 0,   32};
    tbl[4] = '{1'b0, 4'd15, 4'd15, 2'd2, 0, 1'b1, 0,   64};
    tbl[5] = '{1'b1, 4'd5,  4'd11, 2'd2, 0, 1'b0, 0,   64};

    // Reset state and quiet idle after release
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; op_a = '0; op_b = '0; len_sel = '0;
    ma = 31'h1; mb = 31'h2; last_res = '0;
    #1;
    check("reset_outputs", {ready, busy, done, result}, {1'b1, 1'b0, 1'b0, 8'd0});
    #20;
    @(negedge clk) rst_n = 1'b1;
    err = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if ({ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 8'd0}) err++;
    end
    check("idle_after_reset", err, 0);

    for (int i = 0; i < 6; i++)
      full_op($sformatf("tbl%0d", i), tbl[i].md, tbl[i].a, tbl[i].b, tbl[i].ls,
              tbl[i].restart_at, tbl[i].abort_done, 0, tbl[i].lo, tbl[i].hi);

    // Back-to-back with L=16: second start in the first idle cycle
    full_op("b2b_first", 1'b0, 4'd7, 4'd12, 2'd0, 0, 1'b0, 19, 0, 16);
    full_op("b2b_second", 1'b1, 4'd3, 4'd9, 2'd0, 0, 1'b0, 0, 0, 16);

    // Abort at T+10 with L=32: nine generator steps happen before it
    r1 = last_res;
`ifdef SC_RESEED_EN
    ma = 31'h1; mb = 31'h2;
`endif
    void'(model_run(1'b0, 4'd6, 4'd6, 9));
    do_op(1'b0, 4'd6, 4'd6, 2'd1, 10, 0, 1'b0, 40, dc, nd, r, hs);
    check("abort_no_done", nd, 0);
    check("abort_handshake_errs", hs, 0);
    check("abort_result_kept", result, r1);

    // abort and start together in IDLE: start not accepted
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("abort_wins_idle", {ready, busy}, 2'b10);
    start = 1'b0; abort = 1'b0;
    err = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || ready !== 1'b1) err++;
    end
    check("abort_wins_quiet", err, 0);

    // Random operations against the model
    for (int i = 0; i < 12; i++)
      full_op($sformatf("rand%0d", i), 1'($urandom), 4'($urandom), 4'($urandom),
              2'($urandom_range(0, 1)), (i % 3 == 0) ? int'($urandom_range(1, 15)) : 0,
              1'($urandom), 0, 0, 255);

    // Identical operations twice
    full_op("repeat_a", 1'b1, 4'd5, 4'd11, 2'd2, 0, 1'b0, 0, 0, 64);
    r1 = last_res;
    full_op("repeat_b", 1'b1, 4'd5, 4'd11, 2'd2, 0, 1'b0, 0, 0, 64);
`ifdef SC_RESEED_EN
    check("reseed_equal", last_res, r1);
`endif

    // Reset in the middle of an operation
    mode = 1'b0; op_a = 4'd9; op_b = 4'd9; len_sel = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midop_reset", {ready, busy, done, result}, {1'b1, 1'b0, 1'b0, 8'd0});
    ma = 31'h1; mb = 31'h2;
    @(negedge clk) rst_n = 1'b1;
    err = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      if (done !== 1'b0) err++;
    end
    check("midop_reset_no_done", err, 0);
    full_op("post_reset", 1'b0, 4'd10, 4'd13, 2'd1, 0, 1'b0, 0, 0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sc_mult_sequencer.md
SC_MULT_SEQUENCER -- requirements
Module: sc_mult_sequencer

Interface
REQ-001 Parameter BITS, default 4: operand probability width; operand value p encodes probability p/2^BITS.
REQ-002 Parameter CNT_W, default 8: result width; the value SHALL be at least 8 so that it can hold 128.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request, sampled only while ready=1.
REQ-006 abort  input  1  cancels the operation in flight.
REQ-007 op_a  input  BITS  operand A probability.
REQ-008 op_b  input  BITS  operand B probability.
REQ-009 mode  input  1  selects 0 = unipolar multiply (AND) or 1 = bipolar multiply (XNOR).
REQ-010 len_sel  input  2  selects stream length L = 16 << len_sel, giving 16, 32, 64 or 128.
REQ-011 ready  output  1  high in IDLE only.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 result  output  CNT_W  count of 1s in the last completed product stream.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE -> RUN on start=1 and abort=0 at edge T (acceptance).
  - Capture op_a, op_b, mode and L.
  - Clear the ones counter and the stream counter.
REQ-017 Changes to inputs after acceptance SHALL have no effect on the operation in flight.
REQ-018 Each RUN cycle SHALL perform all of the following:
  - Advance both 31-bit LFSRs one step.
    - LFSR A feedback = a[30]^a[27].
    - LFSR B feedback = b[30]^b[2].
  - Register SN_A = (a[30:31-BITS] < op_a) and SN_B = (b[30:31-BITS] < op_b).
  - Increment the stream counter.
REQ-019 Product bit = SN_A & SN_B (mode 0) or ~(SN_A ^ SN_B) (mode 1), formed from the registered SN bits.
REQ-020 The ones counter SHALL add the product bit in the cycle following the one that registered the SN bits.
REQ-021 RUN SHALL last exactly L cycles and then go to DRAIN; DRAIN lasts 1 cycle and counts the final product bit, then goes to DONE.
REQ-022 DONE lasts 1 cycle, then returns to IDLE.
  - done=1 and result = ones count.
  - done SHALL first be high L+2 cycles after edge T.
REQ-023 result SHALL hold its value until the next DONE; 0 <= result <= L, with no overflow possible.
REQ-024 The LFSRs SHALL hold state outside RUN.
REQ-025 start while ready=0 SHALL be ignored and not queued.
REQ-026 abort=1 in RUN or DRAIN:
  - Next state IDLE.
  - No done pulse.
  - result unchanged.
  - LFSR state retained.
REQ-027 abort and start both high in IDLE: abort wins and start is not accepted.
REQ-028 abort in DONE SHALL be ignored; the done pulse completes.
REQ-029 L=16, back-to-back starts: a new start SHALL be accepted in the first IDLE cycle after DONE.

Reset
REQ-030 rst_n low SHALL asynchronously force:
  - FSM to IDLE.
  - ready=1, busy=0, done=0, result=0.
  - Both counters and captured operands to 0, SN bits to 0.
  - LFSR A to 31'h1 and LFSR B to 31'h2.
REQ-031 Reset asserted mid-operation SHALL discard that operation with no done pulse.
REQ-032 Reset deassertion SHALL NOT by itself produce done.

Configuration
REQ-033 Macro SC_RESEED_EN defined: on every accepted start, LFSR A loads 31'h1 and LFSR B loads 31'h2, so identical inputs give identical results.
REQ-034 Macro SC_RESEED_EN undefined: the LFSRs continue from their prior state across operations.

Structure
REQ-035 Shared package sc_pkg SHALL hold:
  - FSM state enum type.
  - LFSR width 31.
  - Seed constants 31'h1 and 31'h2.
  - Tap index constants.
  - Mode encodings.
  - Base length 16.
REQ-036 Sub-module sc_lfsr31 SHALL provide:
  - Parameters: tap and seed.
  - Inputs: step, load.
  - Output: 31-bit state.
  - It is instantiated twice.

Verification
REQ-037 Reset release, no start -> ready=1, busy=0, done=0, result=0 indefinitely.
REQ-038 mode=0, op_a=0, op_b=9, len_sel=0, start at T -> done at T+18, result=0.
REQ-039 mode=1, op_a=0, op_b=0, len_sel=3 -> done at T+130, result=128.
REQ-040 mode=0, op_a=8, op_b=8, len_sel=3 -> result within 16..48; pulse start again at T+5 -> ignored, and a single done at T+130.
REQ-041 abort at T+10, len_sel=1 -> ready=1 at T+11, no done, result keeps its previous value.
REQ-042 SC_RESEED_EN defined, two identical operations (mode=1, op_a=5, op_b=11, len_sel=2) -> equal results; with the macro undefined, the bench checks against a reference model that carries LFSR state across operations.
